// File: rtl/rdid_pkg.sv
// Shared definitions for the RDID responder and the master-side ID compare logic.
// Holds the state encoding, the RDID opcode and the default JEDEC ID bytes.
package rdid_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      RESP,
      IGNORE
   } rdid_state_t;

   localparam logic [7:0] RDID_OPCODE  = 8'h9F;
   localparam logic [7:0] DEF_MAN_ID   = 8'h20;
   localparam logic [7:0] DEF_MEM_TYPE = 8'h20;
   localparam logic [7:0] DEF_MEM_CAP  = 8'h15;

   // The response is a repeating three-byte sequence: 0, 1, 2, 0, ...
   function automatic logic [1:0] next_byte_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// N-stage synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_input_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              q_prev;

   // NOTE: non-blocking assignments make every stage take the previous stage's
   // old value, so the chain really is STAGES flops deep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain  <= {STAGES{RESET_VAL}};
         q_prev <= RESET_VAL;
      end else begin
         chain  <= {chain[STAGES-2:0], d};
         q_prev <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~q_prev;
   assign fall = ~q & q_prev;

endmodule

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 slave that answers the RDID opcode with manufacturer ID, memory
// type and capacity, oversampling the SPI pins in the CCLK domain.
module spi_rdid_responder
   import rdid_pkg::*;
#(
   parameter logic [7:0] MAN_ID      = DEF_MAN_ID,
   parameter logic [7:0] MEM_TYPE    = DEF_MEM_TYPE,
   parameter logic [7:0] MEM_CAP     = DEF_MEM_CAP,
   parameter logic [7:0] RDID_CMD    = RDID_OPCODE,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       CCLK,
   input  logic       reset,
   input  logic       SPICLK,
   input  logic       SPIMOSI,
   input  logic       SPISF,
   output logic       SPIMISO,
   output logic       miso_oe,
   output logic       busy,
   output logic       cmd_valid,
   output logic [7:0] last_cmd,
   output logic [7:0] rdid_count
);

   logic sck_sync, sck_rise, sck_fall;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
   logic sf_sync, sf_rise_unused, sf_fall_unused;

   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk(CCLK), .reset(reset), .d(SPICLK),
      .q(sck_sync), .rise(sck_rise), .fall(sck_fall)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
      .clk(CCLK), .reset(reset), .d(SPIMOSI),
      .q(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sf_sync (
      .clk(CCLK), .reset(reset), .d(SPISF),
      .q(sf_sync), .rise(sf_rise_unused), .fall(sf_fall_unused)
   );

   assign busy = ~sf_sync;

   rdid_state_t state;
   logic [2:0]  bit_cnt;
   logic [7:0]  cmd_sr;
   logic [1:0]  byte_idx;
   logic [2:0]  bit_idx;
   logic [7:0]  next_cmd;
   logic [7:0]  resp_byte;

   assign next_cmd = {cmd_sr[6:0], mosi_sync};

   // NOTE: the default arm keeps this purely combinational; a missing arm
   // would infer a latch on resp_byte.
   always_comb begin
      case (byte_idx)
         2'd0:    resp_byte = MAN_ID;
         2'd1:    resp_byte = MEM_TYPE;
         default: resp_byte = MEM_CAP;
      endcase
   end

   always_ff @(posedge CCLK or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         cmd_sr     <= 8'h00;
         byte_idx   <= 2'd0;
         bit_idx    <= 3'd7;
         SPIMISO    <= 1'b0;
         miso_oe    <= 1'b0;
         cmd_valid  <= 1'b0;
         last_cmd   <= 8'h00;
         rdid_count <= 8'h00;
      end else begin
         cmd_valid <= 1'b0;
         // Deselect is checked first so it beats a coincident SPICLK edge.
         if (sf_sync) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            bit_idx  <= 3'd7;
            SPIMISO  <= 1'b0;
            miso_oe  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= CMD;
                  bit_cnt <= 3'd0;
               end
               CMD: begin
                  if (sck_rise) begin
                     cmd_sr  <= next_cmd;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        last_cmd  <= next_cmd;
                        cmd_valid <= 1'b1;
                        if (next_cmd == RDID_CMD) begin
                           rdid_count <= rdid_count + 8'd1;
                           byte_idx   <= 2'd0;
                           bit_idx    <= 3'd7;
                           state      <= RESP;
                        end else begin
                           state <= IGNORE;
                        end
                     end
                  end
               end
               RESP: begin
                  if (sck_fall) begin
                     miso_oe <= 1'b1;
                     SPIMISO <= resp_byte[bit_idx];
                     bit_idx <= bit_idx - 3'd1;
                     if (bit_idx == 3'd0) byte_idx <= next_byte_idx(byte_idx);
                  end
               end
               IGNORE: begin
                  SPIMISO <= 1'b0;
                  miso_oe <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Directed bench for spi_rdid_responder: a bit-banged mode-0 master drives
// command frames and checks the returned ID bytes and status outputs.
module tb_spi_rdid_responder;

   localparam int SYNC = 2;

   logic       CCLK = 1'b0;
   logic       reset, SPICLK, SPIMOSI, SPISF;
   logic       SPIMISO, miso_oe, busy, cmd_valid;
   logic [7:0] last_cmd, rdid_count;

   int checks   = 0;
   int failures = 0;
   int cv_count = 0;
   int half     = 5;

   logic [7:0] rx [8];
   logic       resp_oe_all, resp_oe_any, cmd_oe_any;
   logic [7:0] miso_or;

   spi_rdid_responder #(.SYNC_STAGES(SYNC)) dut (
      .CCLK(CCLK), .reset(reset), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI),
      .SPISF(SPISF), .SPIMISO(SPIMISO), .miso_oe(miso_oe), .busy(busy),
      .cmd_valid(cmd_valid), .last_cmd(last_cmd), .rdid_count(rdid_count)
   );

   always #5 CCLK = ~CCLK;

   always @(posedge CCLK) if (cmd_valid === 1'b1) cv_count++;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CCLK);
      #1;
   endtask

   task automatic xfer_bit(input logic mo, output logic mi, output logic oe);
      SPIMOSI = mo;
      tick(half);
      mi = SPIMISO;
      oe = miso_oe;
      SPICLK = 1'b1;
      tick(half);
      SPICLK = 1'b0;
   endtask

   task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rxb,
                            output logic oe_a, output logic oe_o);
      logic b, o;
      oe_a = 1'b1;
      oe_o = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(tx[i], b, o);
         rxb[i] = b;
         oe_a &= o;
         oe_o |= o;
      end
   endtask

   task automatic frame(input logic [7:0] cmd, input int nbytes);
      logic [7:0] dummy;
      logic       a, o;
      SPISF = 1'b0;
      tick(half);
      xfer_byte(cmd, dummy, a, o);
      cmd_oe_any  = o;
      resp_oe_all = 1'b1;
      resp_oe_any = 1'b0;
      miso_or     = 8'h00;
      for (int b = 0; b < nbytes; b++) begin
         xfer_byte(8'h00, rx[b], a, o);
         resp_oe_all &= a;
         resp_oe_any |= o;
         miso_or     |= rx[b];
      end
   endtask

   task automatic deselect_dev(input string tag);
      SPISF = 1'b1;
      repeat (SYNC + 1) @(posedge CCLK);
      @(negedge CCLK);
      check({tag, "_oe_drop"}, {31'd0, miso_oe}, 32'd0);
      check({tag, "_miso_idle"}, {31'd0, SPIMISO}, 32'd0);
      tick(half);
   endtask

   initial begin
      int cv_base;
      logic b, o;
      logic [7:0] partial;

      reset = 1'b1; SPICLK = 1'b0; SPIMOSI = 1'b0; SPISF = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(3);
      check("rst_miso", {31'd0, SPIMISO}, 32'd0);
      check("rst_oe", {31'd0, miso_oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      check("rst_last_cmd", {24'd0, last_cmd}, 32'h00);
      check("rst_rdid_count", {24'd0, rdid_count}, 32'd0);

      // 1: basic RDID
      cv_base = cv_count;
      frame(8'h9F, 3);
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_byte0", {24'd0, rx[0]}, 32'h20);
      check("t1_byte1", {24'd0, rx[1]}, 32'h20);
      check("t1_byte2", {24'd0, rx[2]}, 32'h15);
      check("t1_oe_resp", {31'd0, resp_oe_all}, 32'd1);
      check("t1_oe_cmd", {31'd0, cmd_oe_any}, 32'd0);
      check("t1_oe_hold", {31'd0, miso_oe}, 32'd1);
      check("t1_cv_pulses", cv_count - cv_base, 32'd1);
      check("t1_last_cmd", {24'd0, last_cmd}, 32'h9F);
      check("t1_rdid_count", {24'd0, rdid_count}, 32'd1);
      deselect_dev("t1");
      check("t1_busy_off", {31'd0, busy}, 32'd0);

      // 2: foreign opcode is ignored
      cv_base = cv_count;
      frame(8'h03, 3);
      check("t2_oe_any", {31'd0, resp_oe_any}, 32'd0);
      check("t2_miso_any", {24'd0, miso_or}, 32'd0);
      check("t2_last_cmd", {24'd0, last_cmd}, 32'h03);
      check("t2_rdid_count", {24'd0, rdid_count}, 32'd1);
      check("t2_cv_pulses", cv_count - cv_base, 32'd1);
      deselect_dev("t2");

      // 3: aborted command after 5 bits, then a clean RDID
      cv_base = cv_count;
      partial = 8'h9F;
      SPISF = 1'b0;
      tick(half);
      for (int i = 7; i >= 3; i--) xfer_bit(partial[i], b, o);
      deselect_dev("t3_abort");
      check("t3_abort_cv", cv_count - cv_base, 32'd0);
      check("t3_abort_last_cmd", {24'd0, last_cmd}, 32'h03);
      frame(8'h9F, 3);
      check("t3_byte0", {24'd0, rx[0]}, 32'h20);
      check("t3_byte1", {24'd0, rx[1]}, 32'h20);
      check("t3_byte2", {24'd0, rx[2]}, 32'h15);
      check("t3_rdid_count", {24'd0, rdid_count}, 32'd2);
      deselect_dev("t3");

      // 4: response wraps after the third byte
      frame(8'h9F, 5);
      check("t4_byte0", {24'd0, rx[0]}, 32'h20);
      check("t4_byte1", {24'd0, rx[1]}, 32'h20);
      check("t4_byte2", {24'd0, rx[2]}, 32'h15);
      check("t4_byte3", {24'd0, rx[3]}, 32'h20);
      check("t4_byte4", {24'd0, rx[4]}, 32'h20);
      check("t4_oe_resp", {31'd0, resp_oe_all}, 32'd1);
      check("t4_rdid_count", {24'd0, rdid_count}, 32'd3);
      deselect_dev("t4");

      // 5: reset in the middle of the response
      frame(8'h9F, 1);
      for (int i = 0; i < 4; i++) xfer_bit(1'b0, b, o);
      check("t5_pre_byte0", {24'd0, rx[0]}, 32'h20);
      check("t5_pre_oe", {31'd0, miso_oe}, 32'd1);
      check("t5_pre_rdid_count", {24'd0, rdid_count}, 32'd4);
      reset = 1'b1;
      #2;
      check("t5_rst_miso", {31'd0, SPIMISO}, 32'd0);
      check("t5_rst_oe", {31'd0, miso_oe}, 32'd0);
      check("t5_rst_rdid_count", {24'd0, rdid_count}, 32'd0);
      check("t5_rst_last_cmd", {24'd0, last_cmd}, 32'h00);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      tick(3);
      reset = 1'b0;
      tick(5);
      deselect_dev("t5_reselect");
      frame(8'h9F, 3);
      check("t5_byte0", {24'd0, rx[0]}, 32'h20);
      check("t5_byte1", {24'd0, rx[1]}, 32'h20);
      check("t5_byte2", {24'd0, rx[2]}, 32'h15);
      check("t5_rdid_count", {24'd0, rdid_count}, 32'd1);
      deselect_dev("t5");

      // 6: 257 back-to-back frames at the fastest allowed SPICLK
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      check("t6_start_count", {24'd0, rdid_count}, 32'd0);
      half = 4;
      cv_base = cv_count;
      for (int f = 0; f < 257; f++) begin
         int n;
         n = (f == 0 || f == 256) ? 3 : 1;
         frame(8'h9F, n);
         check($sformatf("t6_f%0d_byte0", f), {24'd0, rx[0]}, 32'h20);
         if (n == 3) begin
            check($sformatf("t6_f%0d_byte1", f), {24'd0, rx[1]}, 32'h20);
            check($sformatf("t6_f%0d_byte2", f), {24'd0, rx[2]}, 32'h15);
         end
         deselect_dev($sformatf("t6_f%0d", f));
      end
      check("t6_rdid_wrap", {24'd0, rdid_count}, 32'd1);
      check("t6_cv_pulses", cv_count - cv_base, 32'd257);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
